// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: data-cache handshake, load alignment and the MEM/WB register.
// Optional build macro MEM_MISALIGN_EXP_EN enables misaligned-access exceptions.
`ifndef WORD_DATA_W
`define WORD_DATA_W 32
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef MEM_OP_W
`define MEM_OP_W 4
`endif
`ifndef HART_ID_W
`define HART_ID_W 2
`endif
`ifndef ISA_EXP_W
`define ISA_EXP_W 3
`endif
`ifndef EXP_NO_EXP
`define EXP_NO_EXP 3'h0
`endif
`ifndef EXP_LOAD_MISALIGNED
`define EXP_LOAD_MISALIGNED 3'h4
`endif
`ifndef EXP_STORE_MISALIGNED
`define EXP_STORE_MISALIGNED 3'h6
`endif
`ifndef DISABLE_
`define DISABLE_ 1'b1
`endif

module mem_access_unit (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   ex_en,
  input  logic [`WORD_DATA_W-1:0] ex_pc,
  input  logic [`ISA_EXP_W-1:0]  ex_exp_code,
  input  logic [`MEM_OP_W-1:0]   ex_mem_op,
  input  logic [`WORD_DATA_W-1:0] ex_mem_wr_data,
  input  logic [`WORD_DATA_W-1:0] ex_out,
  input  logic [`REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                   ex_gpr_we_,
  input  logic [`HART_ID_W-1:0]  ex_hart_id,
  output logic                   dc_req,
  output logic                   dc_rw,
  output logic [31:0]            dc_addr,
  output logic [3:0]             dc_byte_en,
  output logic [31:0]            dc_wr_data,
  input  logic [31:0]            dc_rd_data,
  input  logic                   dc_ready,
  output logic                   mem_busy,
  output logic                   mem_en,
  output logic [`WORD_DATA_W-1:0] mem_pc,
  output logic [`ISA_EXP_W-1:0]  mem_exp_code,
  output logic [`WORD_DATA_W-1:0] mem_out,
  output logic [`REG_ADDR_W-1:0] mem_rd_addr,
  output logic                   mem_gpr_we_,
  output logic [`HART_ID_W-1:0]  mem_hart_id
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_next;
  logic        hold_vld_p0;
  logic [31:0] hold_out_p0;
  logic        kill;
  logic        is_mem, is_store, is_load;
  logic [1:0]  size, ofs;
  logic        misaligned, mis_exp, access, complete, update;
  logic [31:0] out_next;

  function automatic logic [31:0] load_align(input logic [31:0] rd, input logic [1:0] ofs_a,
                                             input logic [1:0] size_a, input logic uns);
    logic [31:0] sh;
    sh = rd >> {ofs_a, 3'b000};
    case (size_a)
      2'b00:   load_align = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   load_align = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_align = rd;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input logic [31:0] d, input logic [1:0] size_a);
    case (size_a)
      2'b00:   store_rep = {4{d[7:0]}};
      2'b01:   store_rep = {2{d[15:0]}};
      default: store_rep = d;
    endcase
  endfunction

  function automatic logic [3:0] lanes(input logic [1:0] ofs_a, input logic [1:0] size_a);
    case (size_a)
      2'b00:   lanes = 4'b0001 << ofs_a;
      2'b01:   lanes = 4'b0011 << ofs_a;
      default: lanes = 4'b1111;
    endcase
  endfunction

  assign size     = ex_mem_op[1:0];
  assign is_mem   = ex_mem_op[3:2] != 2'b00;
  assign is_store = ex_mem_op[3:2] == 2'b10;
  assign is_load  = is_mem & ~is_store;

`ifdef MEM_MISALIGN_EXP_EN
  assign ofs        = ex_out[1:0];
  assign misaligned = (size == 2'b01 & ex_out[0]) | (size[1] & ex_out[1:0] != 2'b00);
`else
  // Without exceptions, the low address bits below the access size are ignored.
  assign ofs        = (size == 2'b01) ? {ex_out[1], 1'b0} : (size[1] ? 2'b00 : ex_out[1:0]);
  assign misaligned = 1'b0;
`endif

  assign mis_exp = ex_en & is_mem & (ex_exp_code == `EXP_NO_EXP) & misaligned;
  assign access  = ex_en & is_mem & (ex_exp_code == `EXP_NO_EXP) & ~misaligned;

  assign dc_rw      = is_store;
  assign dc_addr    = {ex_out[31:2], 2'b00};
  assign dc_byte_en = lanes(ofs, size);
  assign dc_wr_data = store_rep(ex_mem_wr_data, size);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A buffered result (hold_vld_p0) blocks a repeat request for the same held access.
  always_comb begin
    state_next = state;
    dc_req     = 1'b0;
    mem_busy   = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (access & ~hold_vld_p0) begin
          dc_req = 1'b1;
          if (dc_ready) complete = 1'b1;
          else begin
            mem_busy   = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        dc_req = 1'b1;
        if (dc_ready) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else begin
          mem_busy = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign update   = ~stall & ~mem_busy;
  assign out_next = (access & is_load) ? load_align(dc_rd_data, ofs, size, ex_mem_op[3]) : ex_out;

  // Stage p0: completion buffer and kill flag
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld_p0 <= 1'b0;
      kill        <= 1'b0;
    end else if (update) begin
      hold_vld_p0 <= 1'b0;
      kill        <= 1'b0;
    end else begin
      if (complete)         hold_vld_p0 <= 1'b1;
      if (flush & mem_busy) kill        <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (complete & ~update) hold_out_p0 <= out_next;
  end

  // Stage p1: MEM/WB register
  always_ff @(posedge clk) begin
    if (reset || (update && (flush || kill))) begin
      mem_en       <= 1'b0;
      mem_pc       <= '0;
      mem_exp_code <= `EXP_NO_EXP;
      mem_out      <= '0;
      mem_rd_addr  <= '0;
      mem_gpr_we_  <= `DISABLE_;
      mem_hart_id  <= '0;
    end else if (update) begin
      mem_en       <= ex_en;
      mem_pc       <= ex_pc;
      mem_rd_addr  <= ex_rd_addr;
      mem_hart_id  <= ex_hart_id;
      mem_exp_code <= mis_exp ? (is_store ? `EXP_STORE_MISALIGNED : `EXP_LOAD_MISALIGNED)
                              : ex_exp_code;
      mem_gpr_we_  <= mis_exp ? `DISABLE_ : ex_gpr_we_;
      mem_out      <= hold_vld_p0 ? hold_out_p0 : out_next;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hits, misses, lanes, misalignment, flush, stall and reset.
`ifndef EXP_NO_EXP
`define EXP_NO_EXP 3'h0
`endif
`ifndef EXP_LOAD_MISALIGNED
`define EXP_LOAD_MISALIGNED 3'h4
`endif

module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        ex_en;
  logic [31:0] ex_pc;
  logic [2:0]  ex_exp_code;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data, ex_out;
  logic [4:0]  ex_rd_addr;
  logic        ex_gpr_we_;
  logic [1:0]  ex_hart_id;
  logic        dc_req, dc_rw;
  logic [31:0] dc_addr;
  logic [3:0]  dc_byte_en;
  logic [31:0] dc_wr_data, dc_rd_data;
  logic        dc_ready, mem_busy, mem_en;
  logic [31:0] mem_pc;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;
  logic [4:0]  mem_rd_addr;
  logic        mem_gpr_we_;
  logic [1:0]  mem_hart_id;

  int checks = 0;
  int errors = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_en(ex_en), .ex_pc(ex_pc), .ex_exp_code(ex_exp_code), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_out(ex_out), .ex_rd_addr(ex_rd_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_hart_id(ex_hart_id),
    .dc_req(dc_req), .dc_rw(dc_rw), .dc_addr(dc_addr), .dc_byte_en(dc_byte_en),
    .dc_wr_data(dc_wr_data), .dc_rd_data(dc_rd_data), .dc_ready(dc_ready),
    .mem_busy(mem_busy), .mem_en(mem_en), .mem_pc(mem_pc), .mem_exp_code(mem_exp_code),
    .mem_out(mem_out), .mem_rd_addr(mem_rd_addr), .mem_gpr_we_(mem_gpr_we_),
    .mem_hart_id(mem_hart_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] exc, input logic we_);
    ex_en          = 1'b1;
    ex_mem_op      = op;
    ex_out         = addr;
    ex_mem_wr_data = wd;
    ex_exp_code    = exc;
    ex_gpr_we_     = we_;
    ex_pc          = 32'h40;
    ex_rd_addr     = 5'd7;
    ex_hart_id     = 2'd1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},  dc_req, 0);
    check({tag, "_busy"}, mem_busy, 0);
    check({tag, "_en"},   mem_en, 0);
    check({tag, "_pc"},   mem_pc, 0);
    check({tag, "_exp"},  mem_exp_code, `EXP_NO_EXP);
    check({tag, "_out"},  mem_out, 0);
    check({tag, "_rd"},   mem_rd_addr, 0);
    check({tag, "_we"},   mem_gpr_we_, 1);
    check({tag, "_hart"}, mem_hart_id, 0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    ex_en = 1'b0; ex_pc = '0; ex_exp_code = '0; ex_mem_op = '0; ex_mem_wr_data = '0;
    ex_out = '0; ex_rd_addr = '0; ex_gpr_we_ = 1'b1; ex_hart_id = '0;
    dc_rd_data = '0; dc_ready = 1'b0;
    step(); step();
    check_reset_state("rst");
    reset = 1'b0;

    // LW 0x100, hit
    set_ex(4'b0110, 32'h100, 32'h0, `EXP_NO_EXP, 1'b0);
    dc_ready = 1'b1; dc_rd_data = 32'hDEADBEEF;
    #1;
    check("lw_req", dc_req, 1);
    check("lw_busy", mem_busy, 0);
    check("lw_addr", dc_addr, 32'h100);
    check("lw_be", dc_byte_en, 4'hF);
    check("lw_rw", dc_rw, 0);
    step();
    check("lw_out", mem_out, 32'hDEADBEEF);
    check("lw_en", mem_en, 1);
    check("lw_we", mem_gpr_we_, 0);
    check("lw_rd", mem_rd_addr, 7);
    check("lw_pc", mem_pc, 32'h40);
    check("lw_hart", mem_hart_id, 1);

    // LB signed 0x103, 3-cycle miss
    set_ex(4'b0100, 32'h103, 32'h0, `EXP_NO_EXP, 1'b0);
    dc_ready = 1'b0; dc_rd_data = 32'h0;
    busy_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (mem_busy) busy_cnt++;
      check("lb_req", dc_req, 1);
      check("lb_hold_out", mem_out, 32'hDEADBEEF);
      step();
    end
    dc_ready = 1'b1; dc_rd_data = 32'h80000000;
    #1;
    check("lb_busy_end", mem_busy, 0);
    check("lb_req_end", dc_req, 1);
    check("lb_be", dc_byte_en, 4'b1000);
    step();
    check("lb_busy_cnt", busy_cnt, 3);
    check("lb_out", mem_out, 32'hFFFFFF80);

    // SH 0x102
    set_ex(4'b1001, 32'h102, 32'h0000ABCD, `EXP_NO_EXP, 1'b1);
    dc_ready = 1'b1;
    #1;
    check("sh_req", dc_req, 1);
    check("sh_rw", dc_rw, 1);
    check("sh_be", dc_byte_en, 4'b1100);
    check("sh_wd", dc_wr_data, 32'hABCDABCD);
    step();
    check("sh_out", mem_out, 32'h102);
    check("sh_we", mem_gpr_we_, 1);

    // LHU 0x102 and LH 0x100
    set_ex(4'b1101, 32'h102, 32'h0, `EXP_NO_EXP, 1'b0);
    dc_rd_data = 32'h87654321;
    step();
    check("lhu_out", mem_out, 32'h00008765);
    set_ex(4'b0101, 32'h100, 32'h0, `EXP_NO_EXP, 1'b0);
    dc_rd_data = 32'h0000F00D;
    step();
    check("lh_out", mem_out, 32'hFFFFF00D);

    // LW 0x101, misaligned
    set_ex(4'b0110, 32'h101, 32'h0, `EXP_NO_EXP, 1'b0);
    dc_rd_data = 32'h12345678;
    #1;
`ifdef MEM_MISALIGN_EXP_EN
    check("mis_req", dc_req, 0);
    check("mis_busy", mem_busy, 0);
    step();
    check("mis_exp", mem_exp_code, `EXP_LOAD_MISALIGNED);
    check("mis_we", mem_gpr_we_, 1);
    check("mis_out", mem_out, 32'h101);
`else
    check("mis_req", dc_req, 1);
    check("mis_addr", dc_addr, 32'h100);
    check("mis_be", dc_byte_en, 4'hF);
    step();
    check("mis_exp", mem_exp_code, `EXP_NO_EXP);
    check("mis_we", mem_gpr_we_, 0);
    check("mis_out", mem_out, 32'h12345678);
`endif

    // Incoming exception passes through with no access
    set_ex(4'b0110, 32'h100, 32'h0, 3'h2, 1'b0);
    #1;
    check("exc_req", dc_req, 0);
    step();
    check("exc_code", mem_exp_code, 3'h2);
    check("exc_out", mem_out, 32'h100);
    check("exc_en", mem_en, 1);

    // Flush during a 4-cycle miss
    set_ex(4'b0110, 32'h200, 32'h0, `EXP_NO_EXP, 1'b0);
    dc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flush = (i == 1);
      #1;
      check("fl_req", dc_req, 1);
      check("fl_busy", mem_busy, 1);
      check("fl_hold_en", mem_en, 1);
      step();
    end
    flush = 1'b0; dc_ready = 1'b1; dc_rd_data = 32'h55555555;
    #1;
    check("fl_req_end", dc_req, 1);
    step();
    check("fl_en", mem_en, 0);
    check("fl_we", mem_gpr_we_, 1);
    check("fl_out", mem_out, 0);
    check("fl_exp", mem_exp_code, `EXP_NO_EXP);

    // Stall at completion: buffered result, no second request
    set_ex(4'b0110, 32'h300, 32'h0, `EXP_NO_EXP, 1'b0);
    stall = 1'b1; dc_ready = 1'b1; dc_rd_data = 32'hCAFEF00D;
    #1;
    check("st_req", dc_req, 1);
    step();
    dc_rd_data = 32'hBADBAD00;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("st_noreq", dc_req, 0);
      check("st_held", mem_out, 0);
      step();
    end
    stall = 1'b0;
    #1;
    check("st_noreq_rel", dc_req, 0);
    step();
    check("st_out", mem_out, 32'hCAFEF00D);
    check("st_en", mem_en, 1);
    #1;
    check("st_next_req", dc_req, 1);
    step();
    check("st_next_out", mem_out, 32'hBADBAD00);

    // Reset while waiting on a miss
    set_ex(4'b0110, 32'h400, 32'h0, `EXP_NO_EXP, 1'b0);
    dc_ready = 1'b0;
    #1;
    check("rw_busy0", mem_busy, 1);
    step();
    check("rw_req1", dc_req, 1);
    check("rw_busy1", mem_busy, 1);
    reset = 1'b1; ex_en = 1'b0; ex_mem_op = 4'b0000;
    step();
    check_reset_state("rwait");
    reset = 1'b0;
    set_ex(4'b0110, 32'h500, 32'h0, `EXP_NO_EXP, 1'b0);
    dc_ready = 1'b1; dc_rd_data = 32'h11111111;
    #1;
    check("rw_after_busy", mem_busy, 0);
    step();
    check("rw_after_out", mem_out, 32'h11111111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store unit at the consumer end of the EX/MEM pipeline register. It takes the registered EX result (address, memory op, store data), performs the data-cache handshake (single-cycle hit or multi-cycle miss), and aligns and sign-extends load data. It raises the pipeline stall request while a miss is outstanding and owns the MEM/WB pipeline register feeding writeback.

## Interface
- No parameters; widths come from the common and core define headers (`WORD_DATA_W`=32, `REG_ADDR_W`=5, `MEM_OP_W`=4, `HART_ID_W`).
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall / flush  in  1 / 1  pipeline control for the MEM/WB register
- ex_en, ex_pc, ex_exp_code, ex_mem_op, ex_mem_wr_data, ex_out, ex_rd_addr, ex_gpr_we_, ex_hart_id  in  (EX/MEM widths)  registered EX/MEM fields; ex_out is the ALU result and the memory address
- dc_req  out  1  cache request, held until dc_ready
- dc_rw  out  1  0 = read, 1 = write
- dc_addr  out  32  word-aligned address ({ex_out[31:2],2'b00})
- dc_byte_en  out  4  byte lanes
- dc_wr_data  out  32  store data replicated to the lanes
- dc_rd_data  in  32  read word, valid with dc_ready
- dc_ready  in  1  completion; may be asserted in the same cycle as dc_req (hit)
- mem_busy  out  1  stall request to hart control
- mem_en, mem_pc, mem_exp_code, mem_out, mem_rd_addr, mem_gpr_we_, mem_hart_id  out  MEM/WB register

## Operation
- mem_op encoding: [3:2] 00 = none, 01 = load signed, 11 = load unsigned, 10 = store. [1:0] 00 = byte, 01 = half, 10 = word.
- Access valid = ex_en & ex_mem_op[3:2]!=00 & ex_exp_code==`EXP_NO_EXP` & no misalignment.
- Byte lanes: byte 0001<<a[1:0]. Half 0011<<a[1:0] (a[1:0] is 0 or 2). Word 1111.
- Store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Load data: lane selected by a[1:0]; sign-extended or zero-extended per mem_op[3].
- FSM IDLE/WAIT:
  - IDLE with a valid access: dc_req=1 combinationally. If dc_ready, complete and stay in IDLE. Otherwise mem_busy=1 and go to WAIT.
  - WAIT: dc_req=1 with unchanged outputs (EX/MEM is held by mem_busy). mem_busy=1 until dc_ready, then go to IDLE.
- MEM/WB updates when stall==0 and mem_busy==0:
  - flush: load NOP values (same as the reset values).
  - Otherwise: mem_out = aligned load data for loads, ex_out for everything else. All other fields pass through.
- Misalignment (half with a[0]=1; word with a[1:0]!=0): no dc_req. mem_exp_code = `EXP_LOAD_MISALIGNED` or `EXP_STORE_MISALIGNED`. mem_gpr_we_ forced `DISABLE_`. mem_out = faulting address.
- An incoming exception code passes through with no cache access.

## Timing
- Reset values: state IDLE; dc_req=0; mem_busy=0; mem_en=0; mem_pc=0; mem_exp_code=`EXP_NO_EXP`; mem_out=0; mem_rd_addr=0; mem_gpr_we_=`DISABLE_`; mem_hart_id=0.
- Hit: dc_req and dc_ready in the same cycle; MEM/WB is loaded at the next edge, with 0 extra cycles.
- Miss: mem_busy is high for N cycles, where N is the number of cycles from the dc_req edge until dc_ready. MEM/WB is loaded at the edge on which dc_ready is sampled.
- dc_req never drops before dc_ready. No new request is issued in the cycle after completion unless EX/MEM has advanced.
- Flush in WAIT: the transaction still completes, a kill flag is set, and MEM/WB receives NOP on completion.
- Stall high at completion: the read data is held in an internal buffer and written to MEM/WB when stall drops. No second dc_req is issued.
- Reset in WAIT: returns to IDLE and deasserts dc_req the next cycle; the cache is reset with the core.

## Configuration
- `MEM_MISALIGN_EXP_EN` defined: misalignment detection and exceptions as described above.
- `MEM_MISALIGN_EXP_EN` undefined: no misalignment exceptions. For halfword accesses a[0] is treated as 0, and for word accesses a[1:0] is treated as 0. The access proceeds, and mem_exp_code passes through unchanged.

## Test plan
- LW at 0x100, dc_ready in the same cycle with rd 0xDEADBEEF -> next edge mem_out=0xDEADBEEF, mem_busy never high.
- LB signed at 0x103, rd 0x80000000, 3-cycle miss -> mem_busy high for 3 cycles, dc_req steady, then mem_out=0xFFFFFF80.
- SH at 0x102 with data 0x0000ABCD -> dc_rw=1, dc_byte_en=1100, dc_wr_data=0xABCDABCD.
- LW at 0x101 with the macro on -> no dc_req, mem_exp_code=`EXP_LOAD_MISALIGNED`, mem_gpr_we_=1. With the macro off -> dc_addr=0x100, normal load.
- Flush during a 4-cycle miss -> dc_req held until dc_ready, then MEM/WB gets NOP (mem_en=0, mem_gpr_we_=1).
- Reset asserted in WAIT -> dc_req=0 and mem_busy=0 after the edge, all MEM/WB outputs at reset values.
